// File: rtl/pu_riscv_membuf_arbiter.sv
// pu_riscv_membuf_arbiter
//   Shares one pipelined memory-side port between NREQ membuf request streams.
//   The request phase is arbitrated (round-robin by default), the grant is held until the
//   memory accepts, and each accepted requester index is queued in an in-order ID FIFO.
//   Each memory response is routed back to the requester at the FIFO head.
//
// Configuration macro:
//   PU_RISCV_MEMBUF_ARB_FIXED_PRIO_EN - when defined, fixed priority (lowest index wins) and
//                                       the round-robin pointer is held at 0.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset (outputs held low while asserted)
//   clr_i        abandon: drop request phase, flush outstanding responses
//   req_i        per-requester request
//   d_i          per-requester payload, requester k at [k*DBITS +: DBITS]
//   ack_o        per-requester accept
//   rsp_valid_o  one-hot response strobe to originator
//   rsp_err_o    response error, qualified by rsp_valid_o
//   mem_req_o    memory request
//   mem_d_o      payload of granted requester (0 when no request)
//   mem_ack_i    memory accepts request this cycle
//   mem_rsp_i    memory response (in order)
//   mem_err_i    memory response error
//   busy_o       responses outstanding or not idle
module pu_riscv_membuf_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned DBITS       = 64,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DBITS-1:0]   d_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         rsp_valid_o,
  output logic                    rsp_err_o,
  output logic                    mem_req_o,
  output logic [DBITS-1:0]        mem_d_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_rsp_i,
  input  logic                    mem_err_i,
  output logic                    busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int unsigned CW = $clog2(MAX_PENDING) + 1;

  typedef enum logic [1:0] {StIdle, StLock, StFlush} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   fifo_q [MAX_PENDING];

  logic [DBITS-1:0] d_arr [NREQ];
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [IW-1:0]    gnt_idx;
  logic             mem_req;
  logic             accept;
  logic             pop;
  logic             full;
  logic             rsp_show;
  logic [IW-1:0]    head_idx;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign d_arr[k] = d_i[k*DBITS +: DBITS];
  end

  function automatic logic [NREQ-1:0] to_oh(input logic [IW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(MAX_PENDING));
  assign head_idx = fifo_q[rd_ptr_q];

  // Scan requesters starting at the pointer; first asserted request wins.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef PU_RISCV_MEMBUF_ARB_FIXED_PRIO_EN
      cand = i;
`else
      cand = (int'(rr_ptr_q) + i) % NREQ;
`endif
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    gnt_idx    = pick_idx;
    mem_req    = 1'b0;

    case (state_q)
      StIdle: begin
        gnt_idx = pick_idx;
        mem_req = pick_vld && !full;
      end
      StLock: begin
        gnt_idx = lock_idx_q;
        mem_req = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase

    if (clr_i) begin
      mem_req = 1'b0;
    end

    accept  = mem_req && mem_ack_i;
    // A response with nothing outstanding is ignored entirely.
    pop     = mem_rsp_i && (count_q != '0);
    count_d = count_q + CW'(accept) - CW'(pop);

    if (clr_i) begin
      state_d = (count_d != '0) ? StFlush : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (mem_req && !mem_ack_i) begin
            state_d    = StLock;
            lock_idx_d = gnt_idx;
          end
        end
        StLock: begin
          if (mem_ack_i) begin
            state_d = StIdle;
          end
        end
        StFlush: begin
          if (count_d == '0) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

`ifdef PU_RISCV_MEMBUF_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`else
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
`endif

    // Responses drained by a flush (or arriving with clr_i) are not forwarded.
    rsp_show = pop && (state_q != StFlush) && !clr_i;
  end

  always_comb begin
    ack_o       = '0;
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_d_o     = '0;
    busy_o      = 1'b0;
    if (rst_ni) begin
      mem_req_o = mem_req;
      if (mem_req) begin
        mem_d_o = d_arr[gnt_idx];
      end
      if (accept) begin
        ack_o = to_oh(gnt_idx);
      end
      if (rsp_show) begin
        rsp_valid_o = to_oh(head_idx);
        rsp_err_o   = mem_err_i;
      end
      busy_o = (count_q != '0) || (state_q != StIdle);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // ID storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept) begin
      fifo_q[wr_ptr_q] <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_pu_riscv_membuf_arbiter.sv
// Bench for pu_riscv_membuf_arbiter (NREQ=2, DBITS=64, MAX_PENDING=4).
// Stimulus pushes expected accepts/responses into queues; a negedge monitor pops and compares
// whenever ack_o or rsp_valid_o is non-zero. Direct checks cover idle/hold/flush/reset cases.
module tb_pu_riscv_membuf_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DBITS = 64;
  localparam logic [63:0] D0 = 64'h1111_0000_0000_1111;
  localparam logic [63:0] D1 = 64'h2222_0000_0000_2222;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic [NREQ-1:0]   req;
  logic [NREQ*DBITS-1:0] d;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_err;
  logic              mem_req;
  logic [DBITS-1:0]  mem_d;
  logic              mem_ack;
  logic              mem_rsp;
  logic              mem_err;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  logic [NREQ+DBITS-1:0] ack_q [$];
  logic [NREQ:0]         rsp_q [$];

  pu_riscv_membuf_arbiter #(
    .NREQ        (2),
    .DBITS       (64),
    .MAX_PENDING (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .req_i       (req),
    .d_i         (d),
    .ack_o       (ack),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .mem_req_o   (mem_req),
    .mem_d_o     (mem_d),
    .mem_ack_i   (mem_ack),
    .mem_rsp_i   (mem_rsp),
    .mem_err_i   (mem_err),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] dsel(input int i);
    return (i == 0) ? d[63:0] : d[127:64];
  endfunction

  task automatic exp_ack(input int g);
    ack_q.push_back({oh(g), dsel(g)});
  endtask

  task automatic exp_rsp(input int g, input logic e);
    rsp_q.push_back({oh(g), e});
  endtask

  // Drive inputs just after a posedge and wait for the following negedge to sample.
  task automatic set_in(input logic [1:0] r, input logic a, input logic p, input logic e,
                        input logic c);
    req     = r;
    mem_ack = a;
    mem_rsp = p;
    mem_err = e;
    clr     = c;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever the DUT presents an accept or a response.
  always @(negedge clk) begin
    logic [NREQ+DBITS-1:0] ea;
    logic [NREQ:0]         er;
    if (ack != '0) begin
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", 64'(ack), 64'h0);
      end else begin
        ea = ack_q.pop_front();
        chk("ack_gnt", 64'(ack), 64'(ea[NREQ+DBITS-1:DBITS]));
        chk("ack_data", mem_d, ea[DBITS-1:0]);
      end
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_dest", 64'(rsp_valid), 64'(er[NREQ:1]));
        chk("rsp_err", 64'(rsp_err), 64'(er[0]));
      end
    end
  end

  initial begin
    int g;
    rst_n   = 1'b0;
    d       = {D1, D0};
    set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    adv();
    rst_n = 1'b1;

    // Reset state
    set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_mem_d", mem_d, 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    adv();

    // Test 1: steady 11 requests, responses two cycles after each accept
    for (int k = 0; k < 4; k++) begin
`ifdef PU_RISCV_MEMBUF_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      exp_ack(g);
      exp_rsp(g, k == 1);
    end
    for (int c = 0; c < 6; c++) begin
      set_in((c < 4) ? 2'b11 : 2'b00, c < 4, c >= 2, c == 3, 1'b0);
      if (c < 4) chk("t1_mem_req", 64'(mem_req), 64'h1);
      adv();
    end
    set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_idle_busy", 64'(busy), 64'h0);
    adv();

`ifndef PU_RISCV_MEMBUF_ARB_FIXED_PRIO_EN
    // Test 2: locked grant holds payload while another requester appears (pointer now 0)
    d = {64'hBEEF, 64'hA5};
    set_in(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_mem_req", 64'(mem_req), 64'h1);
    chk("t2_mem_d0", mem_d, 64'hA5);
    chk("t2_ack0", 64'(ack), 64'h0);
    adv();
    for (int c = 0; c < 2; c++) begin
      set_in(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_lock_req", 64'(mem_req), 64'h1);
      chk("t2_lock_d", mem_d, 64'hA5);
      adv();
    end
    exp_ack(0);
    exp_rsp(0, 1'b0);
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();
    set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();

    // Test 3: fill to MAX_PENDING, 5th request held until a response frees a slot (pointer 1)
    d = {D1, D0};
    exp_ack(1);
    exp_ack(0);
    exp_ack(1);
    exp_ack(0);
    exp_rsp(1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();
    end
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_full_req", 64'(mem_req), 64'h0);
    chk("t3_full_ack", 64'(ack), 64'h0);
    chk("t3_full_busy", 64'(busy), 64'h1);
    adv();
    set_in(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_full_rsp_req", 64'(mem_req), 64'h0);
    adv();
    exp_ack(1);
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_unblock_req", 64'(mem_req), 64'h1);
    adv();
    exp_rsp(0, 1'b0);
    exp_rsp(1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      adv();
    end

    // Test 4: accept and response in the same cycle at count 2 (pointer 0)
    exp_ack(1);
    exp_rsp(0, 1'b0);
    set_in(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    adv();
    exp_rsp(1, 1'b0);
    exp_rsp(1, 1'b1);
    set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    set_in(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    adv();
    set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_rsp_empty", 64'(rsp_valid), 64'h0);
    chk("t4_busy_drained", 64'(busy), 64'h0);
    adv();

    // Test 5: clear with three outstanding, flush silently, then serve anew (pointer 0)
    exp_ack(0);
    exp_ack(1);
    exp_ack(0);
    for (int c = 0; c < 3; c++) begin
      set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();
    end
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_clr_req", 64'(mem_req), 64'h0);
    chk("t5_clr_ack", 64'(ack), 64'h0);
    adv();
    set_in(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_flush_req", 64'(mem_req), 64'h0);
    chk("t5_flush_rsp0", 64'(rsp_valid), 64'h0);
    chk("t5_flush_busy0", 64'(busy), 64'h1);
    adv();
    set_in(2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_flush_rsp1", 64'(rsp_valid), 64'h0);
    chk("t5_flush_err1", 64'(rsp_err), 64'h0);
    adv();
    set_in(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_flush_rsp2", 64'(rsp_valid), 64'h0);
    chk("t5_flush_busy2", 64'(busy), 64'h1);
    adv();
    exp_ack(1);
    exp_rsp(1, 1'b0);
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_busy_fell", 64'(busy), 64'h0);
    chk("t5_new_req", 64'(mem_req), 64'h1);
    adv();
    set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();

    // Test 6: reset while locked with two outstanding (pointer 0)
    exp_ack(0);
    exp_ack(0);
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();
    set_in(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();
    set_in(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_lock_req", 64'(mem_req), 64'h1);
    chk("t6_lock_d", mem_d, D1);
    adv();
    rst_n = 1'b0;
    set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    rst_n = 1'b1;
    set_in(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_rst_req", 64'(mem_req), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_rsp", 64'(rsp_valid), 64'h0);
    chk("t6_rst_err", 64'(rsp_err), 64'h0);
    chk("t6_rst_d", mem_d, 64'h0);
    adv();
    set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_rsp_ignored", 64'(rsp_valid), 64'h0);
    adv();
    exp_ack(0);
    exp_rsp(0, 1'b0);
    set_in(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    adv();
    set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
`endif

    set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ack_queue_empty", 64'(ack_q.size()), 64'h0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'h0);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
